// File: rtl/store_buffer.sv
// Posted-store buffer in front of Data_Memory: stores queue in a small FIFO and
// drain on load-free cycles; loads own the port and forward from the youngest match.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          st_valid,
  input  logic [31:0]   st_addr,
  input  logic [31:0]   st_data,
  output logic          st_ready,
  input  logic          ld_valid,
  input  logic [31:0]   ld_addr,
  output logic          ld_hit,
  output logic [31:0]   ld_fwd_data,
  output logic [31:0]   dm_address,
  output logic [31:0]   dm_writedata,
  output logic          dm_memwrite,
  output logic          dm_memread,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [DEPTH-1:0] valid_reg;
  logic [31:0]      addr_reg [DEPTH];
  logic [31:0]      data_reg [DEPTH];
  logic [DEPTH-1:0] match;
  logic [PW-1:0]    fwd_idx;
  logic             push, pop;

  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign st_ready = !full;
  assign count    = count_reg;

  // A full buffer refuses stores even when it drains this cycle.
  assign push = st_valid && !full;
  assign pop  = !ld_valid && !empty;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign match[gi] = valid_reg[gi] && (addr_reg[gi][31:2] == ld_addr[31:2]);
    end
  endgenerate

  // Walk oldest to youngest so the last hit found is the youngest store.
  always_comb begin
    ld_hit      = 1'b0;
    ld_fwd_data = '0;
    fwd_idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = rd_ptr_reg + PW'(k);
      if (match[fwd_idx]) begin
        ld_hit      = 1'b1;
        ld_fwd_data = data_reg[fwd_idx];
      end
    end
  end

  always_comb begin
    dm_address   = '0;
    dm_writedata = '0;
    dm_memwrite  = 1'b0;
    dm_memread   = 1'b0;
    if (ld_valid) begin
      dm_memread = 1'b1;
      dm_address = ld_addr;
    end else if (!empty) begin
      dm_memwrite  = 1'b1;
      dm_address   = addr_reg[rd_ptr_reg];
      dm_writedata = data_reg[rd_ptr_reg];
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      valid_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      // Push and pop never target the same slot: that needs full or empty.
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_ptr_reg == PW'(i)))
          valid_reg[i] <= 1'b1;
        else if (pop && (rd_ptr_reg == PW'(i)))
          valid_reg[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_reg[wr_ptr_reg] <= st_addr;
      data_reg[wr_ptr_reg] <= st_data;
    end
  end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store buffer between the EX/MEM pipeline register and the `Data_Memory` block in the MEM stage. Stores are accepted in one cycle and queued in a small FIFO. Queued stores drain to data memory on cycles when no load needs the memory port. Loads always take priority for the port and are forwarded from the youngest matching queued store, so the pipeline never observes stale data.

## Interface

Parameters:
- `DEPTH`, 4: number of store entries; power of two, 2 to 16.
- `CW`, 3: width of `count`; must equal log2(`DEPTH`)+1.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `st_valid`, input, 1: store request from EX/MEM.
- `st_addr`, input, 32: store byte address; word-aligned.
- `st_data`, input, 32: store data.
- `st_ready`, output, 1: store accepted this cycle when high together with `st_valid`.
- `ld_valid`, input, 1: load request from EX/MEM.
- `ld_addr`, input, 32: load byte address; word-aligned.
- `ld_hit`, output, 1: a queued store matches `ld_addr`.
- `ld_fwd_data`, output, 32: data of the youngest matching entry; 0 when `ld_hit`=0.
- `dm_address`, output, 32: to `Data_Memory` `address`.
- `dm_writedata`, output, 32: to `Data_Memory` `writedata`.
- `dm_memwrite`, output, 1: to `Data_Memory` `memwrite`.
- `dm_memread`, output, 1: to `Data_Memory` `memread`.
- `count`, output, `CW`: number of valid entries.
- `full`, output, 1: high when `count`==`DEPTH`.
- `empty`, output, 1: high when `count`==0.

## Operation

Storage:
- Circular FIFO with `DEPTH` entries. Each entry holds {valid, addr[31:0], data[31:0]}.
- Head pointer `rd_ptr` and tail pointer `wr_ptr`, each log2(`DEPTH`) bits, both wrap modulo `DEPTH`.

Enqueue:
- `st_ready` = !`full`. This is conservative: a same-cycle drain does not open a slot while `full`=1.
- When `st_valid` and `st_ready` are both high: write the entry at `wr_ptr` and set its valid bit, then `wr_ptr`+1.
- `st_valid` while `full`: nothing is enqueued; upstream holds the request.

Memory port arbitration, combinational from current state and inputs:
- Load cycle (`ld_valid`=1): `dm_memread`=1, `dm_memwrite`=0, `dm_address`=`ld_addr`, `dm_writedata`=0. No drain this cycle.
- Drain cycle (`ld_valid`=0 and `empty`=0): `dm_memwrite`=1, `dm_memread`=0, `dm_address`/`dm_writedata` = head entry. On the edge, clear the head valid bit and `rd_ptr`+1.
- Idle (`ld_valid`=0 and `empty`=1): all `dm_*` outputs 0.

Forwarding:
- Compare `ld_addr` against every valid entry, combinationally. Comparison is on bits [31:2].
- On one or more matches, `ld_hit`=1 and `ld_fwd_data` is the data of the match nearest the tail, i.e. the youngest.
- Forwarding covers only entries already stored. A store presented in the same cycle is not forwarded.
- `ld_hit` is meaningful only when `ld_valid`=1. Downstream muxes `ld_fwd_data` over `Data_Memory` `readdata` when `ld_hit`=1.

Count:
- Push only: `count`+1. Pop only: `count`-1. Push and pop in the same cycle: `count` unchanged.

## Timing

- Reset (`rst_n`=0, asynchronous): pointers=0, `count`=0, all valid bits=0, `empty`=1, `full`=0, `st_ready`=1, `ld_hit`=0, `ld_fwd_data`=0, all `dm_*`=0 once inputs are low. Entries queued before reset are discarded and never written to memory.
- Enqueue latency: an accepted store is visible to forwarding and `count` on the next cycle. It can drain that same next cycle at the earliest.
- Drain throughput: one store per load-free cycle.
- Starvation: continuous `ld_valid` blocks drain indefinitely. The buffer fills and `st_ready` drops. No forced drain is provided.
- Wrap-around: pointers wrap from `DEPTH`-1 to 0 with no bubble.
- Accept and drain when `count`=`DEPTH`-1: both occur, and `count` stays `DEPTH`-1.
- `dm_*` outputs follow input changes in the same cycle. `Data_Memory` samples them on the next rising edge.

## Test plan

1. **Reset.** Assert `rst_n`=0 mid-run with 2 entries queued -> `count`=0, `empty`=1, and no `dm_memwrite` after release.
2. **Enqueue then drain.** Store 0xf14 @0x14, then store 0xa @0x18, with `ld_valid`=0 -> `dm_memwrite` pulses 0x14/0xf14 then 0x18/0xa on consecutive cycles. Memory read of 0x14 returns 0xf14.
3. **Forwarding.** Store 0x11 @0x14, then 0x22 @0x14, hold `ld_valid`=1 with `ld_addr`=0x14 -> `ld_hit`=1, `ld_fwd_data`=0x22, `dm_memread`=1, no drain. A load of 0x1c gives `ld_hit`=0.
4. **Full/backpressure.** With `DEPTH`=4 and continuous loads, present 5 stores -> `full`=1 after the 4th store, `st_ready`=0, and the 5th is held. Dropping `ld_valid` drains the buffer in FIFO order and accepts the 5th.
5. **Simultaneous push/pop and wrap.** Stream 10 stores at 0x00..0x24 with no loads -> `count` stays at 1, the pointers wrap twice, and memory holds all 10 values.
6. **Load priority.** At `count`=2, alternate `ld_valid` on every cycle -> drains occur only on `ld_valid`=0 cycles, and `dm_memread` and `dm_memwrite` are never high together.
